spi_mem_master: RTL and testbench



---
 rtl/spi_mem_master.sv | 123 ++++++++++++
 tb/tb_spi_mem_master.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mem_master.sv
// SPI initiator for the SPI memory responder: one 16-bit frame {addr[6:0], rw, data[7:0]}
// per request, MSB first, sclk idling low with a programmable half-period.
module spi_mem_master #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       cs,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso
);

  typedef enum logic [2:0] {StIdle, StLow, StHigh, StHold, StFin} state_e;

  localparam logic [7:0] DivLast = 8'(CLK_DIV - 1);

  state_e      state_q;
  logic [7:0]  div_q;
  logic [3:0]  bit_q;
  logic [15:0] shift_q;
  logic [7:0]  rx_q;
  logic        rw_q;
  logic        miso_meta_q;
  logic        miso_sync_q;
  logic [15:0] frame;
  logic        div_end;

  // Read frames drive zeros in the data field.
  assign frame   = {addr, rw, rw ? 8'h00 : wdata};
  assign div_end = (div_q == DivLast);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      div_q       <= 8'h00;
      bit_q       <= 4'h0;
      shift_q     <= 16'h0000;
      rx_q        <= 8'h00;
      rw_q        <= 1'b0;
      miso_meta_q <= 1'b0;
      miso_sync_q <= 1'b0;
      rdata       <= 8'h00;
      busy        <= 1'b0;
      done        <= 1'b0;
      cs          <= 1'b1;
      sclk        <= 1'b0;
      mosi        <= 1'b0;
    end else begin
      miso_meta_q <= miso;
      miso_sync_q <= miso_meta_q;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            shift_q <= frame;
            rw_q    <= rw;
            bit_q   <= 4'h0;
            div_q   <= 8'h00;
            cs      <= 1'b0;
            mosi    <= frame[15];
            busy    <= 1'b1;
            state_q <= StLow;
          end
        end
        StLow: begin
          if (div_end) begin
            div_q   <= 8'h00;
            sclk    <= 1'b1;
            state_q <= StHigh;
          end else begin
            div_q <= div_q + 8'h01;
          end
        end
        StHigh: begin
          if (div_end) begin
            div_q <= 8'h00;
            sclk  <= 1'b0;
            rx_q  <= {rx_q[6:0], miso_sync_q};
            if (bit_q != 4'hf) begin
              bit_q   <= bit_q + 4'h1;
              shift_q <= {shift_q[14:0], 1'b0};
              mosi    <= shift_q[14];
              state_q <= StLow;
            end else begin
              mosi    <= 1'b0;
              state_q <= StHold;
            end
          end else begin
            div_q <= div_q + 8'h01;
          end
        end
        StHold: begin
          // Keeps cs low one extra half-period for the responder's hold time.
          if (div_end) begin
            div_q   <= 8'h00;
            cs      <= 1'b1;
            done    <= 1'b1;
            state_q <= StFin;
            if (rw_q) begin
              rdata <= rx_q;
            end
          end else begin
            div_q <= div_q + 8'h01;
          end
        end
        StFin: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_mem_master.sv
// Randomized bench for spi_mem_master: a behavioural SPI memory responder plus a frame-level
// reference model (memory image, expected frame word and timing from the frame formulas).
module tb_spi_mem_master;

  localparam int unsigned Div  = 4;
  localparam int unsigned Div3 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, rw, miso;
  logic [6:0] addr;
  logic [7:0] wdata, rdata;
  logic       busy, done, cs, sclk, mosi;

  logic       reset3, start3, rw3, miso3;
  logic [6:0] addr3;
  logic [7:0] wdata3, rdata3;
  logic       busy3, done3, cs3, sclk3, mosi3;

  spi_mem_master #(.CLK_DIV(Div)) u_dut (
    .clk(clk), .reset(reset), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
    .rdata(rdata), .busy(busy), .done(done), .cs(cs), .sclk(sclk), .mosi(mosi), .miso(miso)
  );

  spi_mem_master #(.CLK_DIV(Div3)) u_dut3 (
    .clk(clk), .reset(reset3), .start(start3), .rw(rw3), .addr(addr3), .wdata(wdata3),
    .rdata(rdata3), .busy(busy3), .done(done3), .cs(cs3), .sclk(sclk3), .mosi(mosi3),
    .miso(miso3)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Responder: samples mosi on sclk rise, drives read data on sclk fall.
  logic [7:0]  resp_mem [128];
  int          resp_bits = 0;
  logic [15:0] resp_sh = 16'h0;
  logic [6:0]  resp_addr = 7'h0;
  logic        resp_rd = 1'b0;

  always @(negedge cs) begin
    resp_bits = 0;
    miso = 1'b0;
  end

  always @(posedge sclk) begin
    if (!cs) begin
      resp_sh = {resp_sh[14:0], mosi};
      resp_bits++;
      if (resp_bits == 8) begin
        resp_addr = resp_sh[7:1];
        resp_rd   = resp_sh[0];
      end
      if (resp_bits == 16 && !resp_rd) resp_mem[resp_addr] = resp_sh[7:0];
    end
  end

  always @(negedge sclk) begin
    logic [7:0] word;
    if (!cs && resp_rd && resp_bits >= 8 && resp_bits <= 15) begin
      word = resp_mem[resp_addr];
      miso = word[15 - resp_bits];
    end
  end

  logic [7:0] ref_mem [128];
  logic [7:0] ref_rdata = 8'h00;

  task automatic do_frame(input logic r, input logic [6:0] a, input logic [7:0] d,
                          input bit poke, input string name);
    logic [15:0] exp_frame, obs_frame;
    int rises = 0, bad_gap = 0, last_rise = 0, first_rise = -1;
    int cs_low = 0, dones = 0, done_k = -10;
    logic [7:0] rd_at_done = 8'h00;
    logic busy_after = 1'b1, prev_sclk = 1'b0;
    exp_frame = {a, r, r ? 8'h00 : d};
    obs_frame = 16'h0;
    @(negedge clk);
    start = 1'b1; rw = r; addr = a; wdata = d;
    @(negedge clk);
    start = 1'b0; rw = 1'($urandom); addr = 7'($urandom); wdata = 8'($urandom);
    for (int k = 0; k < 150; k++) begin
      if (k > 0) @(negedge clk);
      if (!cs) cs_low++;
      if (sclk && !prev_sclk) begin
        obs_frame = {obs_frame[14:0], mosi};
        if (rises == 0) first_rise = k;
        else if (k - last_rise != 2 * Div) bad_gap++;
        last_rise = k;
        rises++;
      end
      prev_sclk = sclk;
      if (k == done_k + 1) busy_after = busy;
      if (done) begin
        dones++;
        done_k = k;
        rd_at_done = rdata;
      end
      start = poke && (k == 40);
      if (poke && k == 40) begin
        addr = ~a; wdata = ~d; rw = ~r;
      end
    end
    start = 1'b0;
    if (r) ref_rdata = ref_mem[a];
    else ref_mem[a] = d;
    check({name, "_frame"}, 32'(obs_frame), 32'(exp_frame));
    check({name, "_rises"}, rises, 16);
    check({name, "_first_rise"}, first_rise, Div);
    check({name, "_rise_gap"}, bad_gap, 0);
    check({name, "_cs_low"}, cs_low, 33 * Div);
    check({name, "_dones"}, dones, 1);
    check({name, "_done_at"}, done_k, 33 * Div);
    check({name, "_rdata_done"}, 32'(rd_at_done), 32'(ref_rdata));
    check({name, "_busy_after"}, 32'(busy_after), 0);
    check({name, "_rdata"}, 32'(rdata), 32'(ref_rdata));
  endtask

  task automatic reset_mid();
    int rises = 0, bad_cs = 0, bad_done = 0;
    logic prev_sclk = 1'b0;
    @(negedge clk);
    start = 1'b1; rw = 1'b0; addr = 7'($urandom); wdata = 8'($urandom);
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (sclk && !prev_sclk) rises++;
      prev_sclk = sclk;
      if (rises == 7) break;
      @(negedge clk);
    end
    check("abort_reached", rises, 7);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ref_rdata = 8'h00;
    check("abort_cs", 32'(cs), 1);
    check("abort_sclk", 32'(sclk), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_rdata", 32'(rdata), 0);
    check("abort_done", 32'(done), 0);
    for (int n = 0; n < 150; n++) begin
      @(negedge clk);
      if (!cs) bad_cs++;
      if (done) bad_done++;
    end
    check("abort_quiet_cs", bad_cs, 0);
    check("abort_quiet_done", bad_done, 0);
  endtask

  task automatic back_to_back();
    int low_run = 0, high_run = 0, runs = 0, bad_low = 0, bad_gap = 0, gaps = 0, dones = 0;
    logic prev_cs = 1'b1;
    bit seen_low = 1'b0;
    @(negedge clk);
    reset3 = 1'b0; start3 = 1'b1;
    rw3 = 1'($urandom); addr3 = 7'($urandom); wdata3 = 8'($urandom);
    for (int k = 0; k < 450; k++) begin
      @(negedge clk);
      if (!cs3) begin
        if (prev_cs && seen_low) begin
          gaps++;
          // Gap is the done cycle plus the idle cycle that samples start again.
          if (high_run != 2) bad_gap++;
        end
        low_run++;
        high_run = 0;
        seen_low = 1'b1;
      end else begin
        if (!prev_cs) begin
          runs++;
          if (low_run != 33 * Div3) bad_low++;
          low_run = 0;
        end
        high_run++;
      end
      if (done3) dones++;
      prev_cs = cs3;
      start3 = (k < 300);
    end
    check("b2b_frames", runs, 3);
    check("b2b_cs_low", bad_low, 0);
    check("b2b_gaps", gaps, 2);
    check("b2b_gap_len", bad_gap, 0);
    check("b2b_dones", dones, runs);
  endtask

  initial begin
    logic [6:0] a;
    logic [7:0] d;
    reset = 1'b1; start = 1'b0; rw = 1'b0; addr = 7'h0; wdata = 8'h0; miso = 1'b0;
    reset3 = 1'b1; start3 = 1'b0; rw3 = 1'b0; addr3 = 7'h0; wdata3 = 8'h0; miso3 = 1'b0;
    for (int i = 0; i < 128; i++) begin
      d = 8'($urandom);
      resp_mem[i] = d;
      ref_mem[i]  = d;
    end
    repeat (3) @(negedge clk);
    check("rst_cs", 32'(cs), 1);
    check("rst_sclk", 32'(sclk), 0);
    check("rst_mosi", 32'(mosi), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_rdata", 32'(rdata), 0);
    reset = 1'b0;

    do_frame(1'b0, 7'h2a, 8'hc3, 1'b0, "wr2a");
    resp_mem[5] = 8'ha5;
    ref_mem[5]  = 8'ha5;
    do_frame(1'b1, 7'h05, 8'hff, 1'b0, "rd05");
    reset_mid();
    do_frame(1'b1, 7'h05, 8'h00, 1'b0, "rd05_again");
    do_frame(1'b0, 7'h11, 8'h5a, 1'b0, "wr11");
    do_frame(1'b1, 7'h11, 8'h00, 1'b0, "rd11");
    do_frame(1'b0, 7'($urandom), 8'($urandom), 1'b1, "poke");
    for (int i = 0; i < 4; i++) begin
      a = 7'($urandom);
      d = 8'($urandom);
      do_frame(1'b0, a, d, 1'b0, "rnd_wr");
      do_frame(1'b1, a, 8'($urandom), 1'b0, "rnd_rd");
      do_frame(1'b1, 7'($urandom), 8'($urandom), 1'b0, "rnd_rd2");
    end

    back_to_back();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
